// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word/PC geometry, fetch FSM states and fetch buffer entry layout.
package cpu_pkg;

    localparam int WORD_W    = 32;
    localparam int PC_STEP   = 4;
    localparam int PC_OFFSET = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: DEPTH entries of {instr, pc}; write visible at head next cycle.
// Push ignored when full, pop ignored when empty; flush empties in one cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // Reset contents so the presented pc reads RESET_PC before any fetch.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{instr: '0, pc: RESET_PC};
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: 1-cycle ack-to-valid through a buffer of depth 2 (FETCH_PREFETCH_EN) or 1;
// stops requesting when the buffer will be full, output held while instr_ready is low.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC       = 32'h0000_0000,
    parameter int                ADDR_ALIGN_CHK = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] Instr,
    output logic [WORD_W-1:0] pcplus8,
    input  logic              PCSrc,
    input  logic [WORD_W-1:0] Result,
    output logic              align_err
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] target_pc;
    logic [WORD_W-1:0] target;
    logic              discard;
    logic              accept;
    logic              redirect;
    logic              ack_in;
    logic              push;
    logic              pop;
    logic              will_fill;
    fetch_entry_t      head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign accept    = instr_valid && instr_ready;
    assign redirect  = accept && PCSrc;
    assign ack_in    = (state == REQ) && imem_ack;
    assign push      = ack_in && !discard && !redirect && !fifo_full;
    assign pop       = accept && !redirect;
    assign target    = {Result[WORD_W-1:2], 2'b00};
    assign will_fill = push && !pop && (fifo_count == CNT_W'(DEPTH - 1));

    fetch_fifo #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry ('{instr: imem_rdata, pc: fetch_pc}),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     if (!redirect && will_fill) state_nxt = FULL;
            FULL:    if (redirect || pop) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            target_pc <= RESET_PC;
            discard   <= 1'b0;
            align_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                // A request already on the bus must complete at its own address; its data is dropped.
                if (state == REQ && !imem_ack) begin
                    discard   <= 1'b1;
                    target_pc <= target;
                end else begin
                    fetch_pc <= target;
                end
            end else if (ack_in) begin
                if (discard) begin
                    fetch_pc <= target_pc;
                    discard  <= 1'b0;
                end else begin
                    fetch_pc <= fetch_pc + WORD_W'(PC_STEP);
                end
            end
            if (redirect && (ADDR_ALIGN_CHK != 0) && (Result[1:0] != 2'b00)) begin
                align_err <= 1'b1;
            end
        end
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = fetch_pc;
    assign instr_valid = !fifo_empty;
    assign Instr       = head.instr;
    assign pcplus8     = head.pc + WORD_W'(PC_OFFSET);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a stream-level reference model and a second instance for PC wrap.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr;
    logic [31:0] pcplus8;
    logic        PCSrc;
    logic [31:0] Result;
    logic        align_err;
    logic        ack_en;

    logic        reset_w;
    logic        req_w, ack_w, valid_w, err_w;
    logic        ready_w  = 1'b1;
    logic        pcsrc_w  = 1'b0;
    logic [31:0] result_w = 32'h0;
    logic [31:0] addr_wo, rdata_w, instr_wo, p8_w;
    logic [31:0] wrap_log [2];
    int          n_w = 0;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] ack_log [$];
    logic [31:0] acc_log [$];

    initial forever #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .ADDR_ALIGN_CHK(1)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Instr(Instr), .pcplus8(pcplus8),
        .PCSrc(PCSrc), .Result(Result), .align_err(align_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .ADDR_ALIGN_CHK(1)) dut_w (
        .clk(clk), .reset(reset_w), .imem_req(req_w), .imem_addr(addr_wo),
        .imem_ack(ack_w), .imem_rdata(rdata_w), .instr_valid(valid_w),
        .instr_ready(ready_w), .Instr(instr_wo), .pcplus8(p8_w),
        .PCSrc(pcsrc_w), .Result(result_w), .align_err(err_w)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Memory responder: acks each request one cycle after it is seen, while ack_en is high.
    initial begin : responder
        int wt;
        wt = 0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                imem_ack = 1'b0; wt = 0;
            end else if (imem_ack) begin
                imem_ack = 1'b0; wt = 0;
            end else if (imem_req && ack_en) begin
                if (wt >= 1) begin
                    imem_ack = 1'b1; imem_rdata = mem_fn(imem_addr);
                end else wt++;
            end
        end
    end

    initial begin : responder_w
        ack_w = 1'b0;
        rdata_w = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset_w || ack_w) ack_w = 1'b0;
            else if (req_w) begin
                ack_w = 1'b1; rdata_w = mem_fn(addr_wo);
            end
        end
    end

    initial begin : monitor_w
        forever begin
            @(negedge clk);
            if (reset_w && req_w && ack_w && n_w < 2) begin
                wrap_log[n_w] = addr_wo;
                n_w++;
            end
        end
    end

    // Stream model: occupancy, next fetch address, next delivered pc, pending-discard flag.
    initial begin : compare
        int          occ, live;
        logic [31:0] exp_fetch, exp_pc, tgt;
        logic        disc, have_prev, ack_now, acc, redir;
        logic        p_req, p_ack, p_valid, p_ready;
        logic [31:0] p_addr, p_instr, p_p8;
        occ = 0; live = 0; disc = 0; have_prev = 0;
        exp_fetch = RST_PC; exp_pc = RST_PC;
        forever begin
            @(negedge clk);
            if (!reset) begin
                occ = 0; live = 0; disc = 0; have_prev = 0;
                exp_fetch = RST_PC; exp_pc = RST_PC;
            end else begin
                if (live > 0) check("req_level", 32'(imem_req), 32'(occ < DEPTH));
                check("valid_level", 32'(instr_valid), 32'(occ > 0));
                if (instr_valid) check("instr_data", Instr, mem_fn(pcplus8 - 32'd8));
                if (have_prev && p_req && !p_ack) begin
                    check("req_hold", 32'(imem_req), 32'd1);
                    check("addr_hold", imem_addr, p_addr);
                end
                if (have_prev && p_valid && !p_ready) begin
                    check("instr_stable", Instr, p_instr);
                    check("pcplus8_stable", pcplus8, p_p8);
                end
                ack_now = imem_req && imem_ack;
                acc     = instr_valid && instr_ready;
                redir   = acc && PCSrc;
                tgt     = {Result[31:2], 2'b00};
                if (ack_now) ack_log.push_back(imem_addr);
                if (acc) begin
                    check("stream_pc", pcplus8 - 32'd8, exp_pc);
                    acc_log.push_back(pcplus8);
                    exp_pc = redir ? tgt : exp_pc + 32'd4;
                end
                if (redir) begin
                    occ = 0;
                    exp_fetch = tgt;
                    disc = imem_req && !imem_ack;
                end else begin
                    if (acc) occ--;
                    if (ack_now) begin
                        if (disc) disc = 0;
                        else begin
                            check("fetch_addr", imem_addr, exp_fetch);
                            occ++;
                            exp_fetch = exp_fetch + 32'd4;
                        end
                    end
                end
                p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
                p_valid = instr_valid; p_ready = instr_ready;
                p_instr = Instr; p_p8 = pcplus8;
                have_prev = 1; live++;
            end
        end
    end

    task automatic wait_acc(input int n, input string name);
        int b;
        b = 0;
        while (acc_log.size() < n && b < 200) begin
            @(posedge clk); #1; b++;
        end
        if (acc_log.size() < n) fail(name);
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        int b;
        b = 0;
        while (!instr_valid && b < 100) begin
            @(posedge clk); #1; b++;
        end
        if (!instr_valid) fail("redirect_wait");
        PCSrc = 1'b1; Result = tgt;
        @(posedge clk); #1;
        PCSrc = 1'b0; Result = '0;
    endtask

    initial begin : main
        int mA, mP, b;
        reset = 1'b0; reset_w = 1'b0;
        instr_ready = 1'b0; PCSrc = 1'b0; Result = '0; ack_en = 1'b0;
        repeat (2) @(posedge clk); #1;

        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", Instr, 32'h0);
        check("rst_pcplus8", pcplus8, 32'h8);
        check("rst_align", 32'(align_err), 32'd0);
        check("rst_w_addr", addr_wo, 32'hFFFF_FFFC);
        check("rst_w_pcplus8", p8_w, 32'h4);

        // Sequential fetch with a consumer that always accepts.
        mA = ack_log.size(); mP = acc_log.size();
        instr_ready = 1'b1; ack_en = 1'b1;
        reset = 1'b1; reset_w = 1'b1;
        wait_acc(mP + 3, "seq_wait");
        check("seq_addr0", ack_log[mA], 32'h0);
        check("seq_addr1", ack_log[mA+1], 32'h4);
        check("seq_addr2", ack_log[mA+2], 32'h8);
        check("seq_p8_0", acc_log[mP], 32'd8);
        check("seq_p8_1", acc_log[mP+1], 32'd12);
        check("seq_p8_2", acc_log[mP+2], 32'd16);

        // Stalled consumer: requests stop once the buffer is full.
        reset = 1'b0; instr_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        mA = ack_log.size();
        repeat (10) @(posedge clk); #1;
        check("stall_acks", 32'(ack_log.size() - mA), 32'(DEPTH));
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_valid", 32'(instr_valid), 32'd1);
        check("stall_instr", Instr, mem_fn(32'h0));
        check("stall_pcplus8", pcplus8, 32'h8);

        // Redirect to 0x100; with prefetch the request for 8 is outstanding and must be dropped.
        ack_en = 1'b0;
        @(posedge clk); #1;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
`ifdef FETCH_PREFETCH_EN
        repeat (2) @(posedge clk); #1;
        check("pend_req", 32'(imem_req), 32'd1);
        check("pend_addr", imem_addr, 32'h8);
`else
        ack_en = 1'b1;
        b = 0;
        while (!instr_valid && b < 50) begin
            @(posedge clk); #1; b++;
        end
        if (!instr_valid) fail("refill_wait");
        ack_en = 1'b0;
`endif
        mA = ack_log.size(); mP = acc_log.size();
        instr_ready = 1'b1;
        do_redirect(32'h100);
        ack_en = 1'b1;
        wait_acc(mP + 2, "redir_wait");
        check("redir_src_p8", acc_log[mP], 32'hC);
        check("redir_first_p8", acc_log[mP+1], 32'h108);
`ifdef FETCH_PREFETCH_EN
        check("redir_drop_addr", ack_log[mA], 32'h8);
        check("redir_addr", ack_log[mA+1], 32'h100);
`else
        check("redir_addr", ack_log[mA], 32'h100);
`endif
        check("align_clean", 32'(align_err), 32'd0);

        // Misaligned target: word-aligned fetch plus sticky error flag.
        mP = acc_log.size();
        do_redirect(32'h102);
        wait_acc(mP + 2, "mis_wait");
        check("mis_first_p8", acc_log[mP+1], 32'h108);
        check("mis_align", 32'(align_err), 32'd1);
        repeat (5) @(posedge clk); #1;
        check("mis_sticky", 32'(align_err), 32'd1);

        // Reset with a request outstanding.
        ack_en = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("pre_rst_req", 32'(imem_req), 32'd1);
        reset = 1'b0;
        #2;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_instr", Instr, 32'h0);
        check("mid_rst_pcplus8", pcplus8, 32'h8);
        check("mid_rst_align", 32'(align_err), 32'd0);
        @(posedge clk); #1;
        ack_en = 1'b1;
        @(posedge clk); #1;
        mA = ack_log.size(); mP = acc_log.size();
        reset = 1'b1;
        wait_acc(mP + 1, "restart_wait");
        check("restart_addr", ack_log[mA], 32'h0);
        check("restart_p8", acc_log[mP], 32'h8);

        check("wrap_addr0", wrap_log[0], 32'hFFFF_FFFC);
        check("wrap_addr1", wrap_log[1], 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter ADDR_ALIGN_CHK, default 1, nonzero enables misaligned-target error flag.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 asserts, release synchronous to clk.
REQ-005 imem_req  out  1  fetch request; held with imem_addr stable until imem_ack.
REQ-006 imem_addr  out  32  word-aligned fetch address.
REQ-007 imem_ack  in  1  one-cycle acknowledge; imem_rdata valid same cycle.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 instr_valid  out  1  Instr/pcplus8 hold a valid instruction.
REQ-010 instr_ready  in  1  consumer (controller/datapath) accepts this cycle.
REQ-011 Instr  out  32  instruction presented to controller (bits 31:12 used there).
REQ-012 pcplus8  out  32  address of presented instruction + 8.
REQ-013 PCSrc  in  1  branch/PC-write redirect, sampled only when instr_valid & instr_ready.
REQ-014 Result  in  32  redirect target, sampled with PCSrc.
REQ-015 align_err  out  1  sticky; accepted redirect target had Result[1:0] != 0.

Function
REQ-016 FSM states: IDLE, REQ, FULL; reset enters IDLE; IDLE -> REQ on first clock after reset release.
REQ-017 REQ drives imem_req=1; on imem_ack stays REQ if buffer space remains after write, else FULL.
REQ-018 FULL drives imem_req=0; returns to REQ cycle after any buffer entry is popped.
REQ-019 Fetch PC starts at RESET_PC, increments by 4 on each non-discarded ack, wraps 32'hFFFF_FFFC -> 0.
REQ-020 Ack in cycle N: data visible on Instr with instr_valid=1 in cycle N+1, never same cycle.
REQ-021 Pop occurs on instr_valid & instr_ready; buffer head advances next cycle.
REQ-022 Accepted PCSrc=1: buffer flushed, fetch PC := {Result[31:2],2'b00}, instr_valid=0 next cycle.
REQ-023 Redirect while request outstanding: req/addr held to ack, that ack's data discarded, then request target next cycle.
REQ-024 Redirect and ack same cycle: ack data discarded, target request issued next cycle.
REQ-025 Pop and ack same cycle when buffer full-minus-one: both succeed, occupancy unchanged.
REQ-026 Instr/pcplus8 stable while instr_valid=1 and instr_ready=0.
REQ-027 align_err set when ADDR_ALIGN_CHK!=0 and accepted target misaligned; cleared only by reset.

Reset
REQ-028 reset=0: imem_req=0, imem_addr=RESET_PC, instr_valid=0, Instr=0, pcplus8=RESET_PC+8, align_err=0, buffer empty, discard flag clear.
REQ-029 Reset mid-transaction: outstanding request abandoned; first ack after release belongs only to new request.

Configuration
REQ-030 Macro FETCH_PREFETCH_EN defined: buffer depth 2, new request may issue while one entry held.
REQ-031 FETCH_PREFETCH_EN undefined: buffer depth 1, at most one instruction buffered or outstanding; FULL whenever occupied.

Structure
REQ-032 Shared package cpu_pkg holds WORD_W=32, PC_STEP=4, PC_OFFSET=8, fetch_state_t enum (IDLE, REQ, FULL).
REQ-033 Sub-module fetch_fifo: parameterised depth, {instr, pc} entries, push/pop/flush, full/empty outputs.

Verification
REQ-034 Release reset, imem_ack one cycle after each req -> imem_addr 0,4,8; Instr order matches; pcplus8 8,12,16.
REQ-035 Hold instr_ready=0 for 10 cycles -> imem_req drops after 2 acks (1 without macro); Instr stable.
REQ-036 Accept instr with PCSrc=1, Result=32'h100 while ack pending -> pending data dropped, next imem_addr 32'h100, first Instr from 0x100.
REQ-037 PCSrc=1, Result=32'h102 -> align_err=1 and stays set; imem_addr 32'h100.
REQ-038 RESET_PC=32'hFFFF_FFFC, two fetches -> addresses FFFF_FFFC then 0000_0000.
REQ-039 Assert reset with req outstanding -> all outputs at REQ-028 values immediately; restart at RESET_PC.
